// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the single-precision normalize/round back
// end. It holds the field widths, the bit positions inside the extended
// significand, the exponent limits, the controller state encoding, and the
// special-value encodings.
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = FRAC_W + 5;
    localparam int RES_W  = 1 + EXP_W + FRAC_W;

    // Bit positions inside the extended significand {carry, hidden, frac, G, R, S}
    localparam int SIG_CARRY  = SIG_W - 1;
    localparam int SIG_HIDDEN = SIG_W - 2;
    localparam int SIG_G      = 2;
    localparam int SIG_R      = 1;
    localparam int SIG_S      = 0;

    // Two extra bits let the exponent grow past 255 on a carry, and they
    // also keep it from wrapping below zero.
    typedef logic signed [EXP_W+1:0] exp_t;

    localparam exp_t EXP_MAX = exp_t'((1 << EXP_W) - 1);
    localparam exp_t EXP_MIN = exp_t'(1);

    localparam logic [RES_W-1:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [RES_W-1:0] FP_POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ROUND,
        PACK,
        DONE
    } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne
// This block rounds to nearest, with ties going to even. It is purely
// combinational.
//   mant_i    : {hidden, frac[FRAC_W-1:0], G, R, S}
//   rounded_o : {carry, hidden, frac[FRAC_W-1:0]} after the optional increment
// ---------------------------------------------------------------------------
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [FRAC_W+3:0] mant_i,
    output logic [FRAC_W+1:0] rounded_o
);

    logic lsb;
    logic guardBit;
    logic roundBit;
    logic stickyBit;
    logic roundInc;

    // The increment happens above the halfway point. On an exact tie it
    // happens only when that brings the kept LSB back to even.
    always_comb begin
        lsb       = mant_i[3];
        guardBit  = mant_i[2];
        roundBit  = mant_i[1];
        stickyBit = mant_i[0];
        roundInc  = guardBit & (roundBit | stickyBit | lsb);
        rounded_o = {1'b0, mant_i[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, roundInc};
    end

endmodule

// File: rtl/fp_normalize_round.sv
// ---------------------------------------------------------------------------
// fp_normalize_round
// This is the back end of the FP add/sub datapath. It takes the raw aligned
// ALU sum and produces a packed IEEE-754 single-precision result. Each cycle
// it makes one normalization step. It then rounds to nearest even and
// re-normalizes if that rounding carries out. Finally it packs the result.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (ready only while idle)
//   in_sign/in_exp/in_sig : sign, aligned biased exponent, extended significand
//   out_valid / out_ready : result handshake (held until accepted)
//   out_result            : {sign, exp, frac}
//   out_zero/out_overflow/out_underflow : status, valid with out_valid
// ---------------------------------------------------------------------------
module fp_normalize_round
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_underflow
);

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    exp_t             exp_q, exp_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             inexact_q, inexact_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [FRAC_W+1:0] rounded;
    logic              sigIsZero;
    logic              needRight;
    logic              needLeft;

    fp_round_rne u_round (
        .mant_i    (sig_q[SIG_HIDDEN:0]),
        .rounded_o (rounded)
    );

    // These are the NORM decision terms, shared by the state logic and the
    // datapath logic. A left shift stops at exponent 1. At that point the
    // value is denormal and the hidden bit stays clear.
    always_comb begin
        sigIsZero = (sig_q == '0);
        needRight = sig_q[SIG_CARRY];
        needLeft  = !sig_q[SIG_HIDDEN] && (exp_q > EXP_MIN);
    end

    // The state register. Reset is asynchronous, so an operation caught
    // mid-flight is dropped immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. NORM stays put while a shift is still needed. A
    // rounding carry sends the flow back to NORM for the single right shift.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = NORM;
            NORM: begin
                if (sigIsZero)                  state_d = DONE;
                else if (needRight || needLeft) state_d = NORM;
                else                            state_d = ROUND;
            end
            ROUND:   state_d = rounded[FRAC_W+1] ? NORM : PACK;
            PACK:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. The handshake signals depend only on the current state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state logic. This covers the shifter, the exponent
    // counter, and the result/flag registers. Bits shifted out on a right
    // shift fold into sticky. The inexact flag records whether rounding ever
    // dropped anything. It decides whether a denormal result counts as an
    // underflow.
    always_comb begin
        sign_d    = sign_q;
        exp_d     = exp_q;
        sig_d     = sig_q;
        inexact_d = inexact_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d    = in_sign;
                    exp_d     = (in_exp == '0) ? EXP_MIN : exp_t'({2'b00, in_exp});
                    sig_d     = in_sig;
                    inexact_d = 1'b0;
                    result_d  = '0;
                    zero_d    = 1'b0;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                end
            end
            NORM: begin
                if (sigIsZero) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                end else if (needRight) begin
                    sig_d = {1'b0, sig_q[SIG_W-1:2], sig_q[SIG_R] | sig_q[SIG_S]};
                    exp_d = exp_q + exp_t'(1);
                end else if (needLeft) begin
                    sig_d = {sig_q[SIG_W-2:0], 1'b0};
                    exp_d = exp_q - exp_t'(1);
                end
            end
            ROUND: begin
                sig_d     = {rounded, 3'b000};
                inexact_d = inexact_q | (|sig_q[SIG_G:SIG_S]);
            end
            PACK: begin
                if (exp_q >= EXP_MAX) begin
                    result_d = FP_POS_INF | {sign_q, {(RES_W-1){1'b0}}};
                    ovf_d    = 1'b1;
                end else if (!sig_q[SIG_HIDDEN]) begin
                    result_d = {sign_q, {EXP_W{1'b0}}, sig_q[SIG_HIDDEN-1:SIG_G+1]};
                    unf_d    = inexact_q;
                end else begin
                    result_d = {sign_q, exp_q[EXP_W-1:0], sig_q[SIG_HIDDEN-1:SIG_G+1]};
                end
            end
            default: ;
        endcase
    end

    // The datapath registers. Their reset values give a clean all-zero
    // result and all-zero flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q    <= 1'b0;
            exp_q     <= '0;
            sig_q     <= '0;
            inexact_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            sig_q     <= sig_d;
            inexact_q <= inexact_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign out_result    = result_q;
    assign out_zero      = zero_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_round
// This bench drives directed and random operands into fp_normalize_round.
// It compares the packed results and the flags against an arithmetic model
// that performs exact round-to-nearest-even on the value sig * 2^(exp-153).
// ---------------------------------------------------------------------------
module tb_fp_normalize_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

    int checkCount  = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        unf;
    } expect_t;

    fp_normalize_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_sig        (in_sig),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    // The free-running clock has a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // This is the single comparison point. It counts every check and
    // reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // The reference model rounds the exact value m * 2^(E-153) to single
    // precision, with denormals allowed. The result's ULP is 2^(be-150),
    // where be is the biased exponent, floored at 1.
    function automatic expect_t refModel(input logic s, input logic [7:0] e, input logic [27:0] m);
        expect_t r;
        int      bigE, p, be, k;
        longint  q, rem, half;
        bit      inexact;
        r = '0;
        inexact = 1'b0;
        if (m == 28'd0) begin
            r.zero = 1'b1;
            return r;
        end
        bigE = (e == 8'd0) ? 1 : int'(e);
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        be = p + bigE - 26;
        if (be < 1) be = 1;
        k = be - bigE + 3;
        if (k > 0) begin
            q    = longint'(m) >> k;
            rem  = longint'(m) - (q << k);
            half = longint'(1) << (k - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = longint'(m) << (-k);
        end
        if (q >= (longint'(1) << 24)) begin
            q = q >> 1;
            be++;
        end
        if (be >= 255) begin
            r.result = {s, 8'hFF, 23'h0};
            r.ovf    = 1'b1;
        end else if (q < (longint'(1) << 23)) begin
            r.result = {s, 8'h00, q[22:0]};
            r.unf    = inexact;
        end else begin
            r.result = {s, be[7:0], q[22:0]};
        end
        return r;
    endfunction

    // This task sends one operand, measures the cycles from accept to
    // out_valid, and checks the result. It then holds out_ready low for
    // holdCycles cycles, checking that the outputs stay stable, and releases
    // the result.
    task automatic applyStimulus(input string tag, input logic s, input logic [7:0] e,
                                 input logic [27:0] m, input int holdCycles, input int expLatency);
        expect_t exp_r;
        int      guard;
        int      latency;
        exp_r = refModel(s, e, m);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_inReady"}, {31'd0, in_ready}, 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_sig   = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_sig   = 28'(($urandom() & 32'h0FFF_FFFF));
        latency  = 0;
        while (!out_valid && latency < 40) begin
            @(negedge clk);
            latency++;
        end
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (expLatency > 0) checkOutput({tag, "_latency"}, latency, expLatency);
        else                checkOutput({tag, "_latencyBound"}, {31'd0, (latency <= 32)}, 32'd1);
        checkOutput({tag, "_result"}, out_result, exp_r.result);
        checkOutput({tag, "_flags"}, {29'd0, out_zero, out_overflow, out_underflow},
                    {29'd0, exp_r.zero, exp_r.ovf, exp_r.unf});
        for (int c = 0; c < holdCycles; c++) begin
            in_valid = 1'b1;
            @(negedge clk);
            checkOutput({tag, "_holdResult"}, out_result, exp_r.result);
            checkOutput({tag, "_holdHandshake"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0]  rExp;
        logic [27:0] rSig;
        int          mode;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_sig    = 28'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        checkOutput("reset_result", out_result, 32'd0);
        checkOutput("reset_flags", {29'd0, out_zero, out_overflow, out_underflow}, 32'd0);

        $display("[TB] directed vectors");
        applyStimulus("onePlusOne",   1'b0, 8'd127, 28'h8000000, 0, 4);
        applyStimulus("oneMinus3q",   1'b0, 8'd127, 28'h1000000, 0, 5);
        applyStimulus("roundCarry",   1'b0, 8'd127, 28'h7FFFFFC, 0, 0);
        applyStimulus("tieEven",      1'b0, 8'd127, 28'h4000004, 0, 0);
        applyStimulus("overflow",     1'b0, 8'd254, 28'h8000000, 0, 0);
        applyStimulus("zero",         1'b1, 8'd127, 28'h0000000, 0, 1);
        applyStimulus("denormExact",  1'b0, 8'd1,   28'h2000000, 0, 0);
        applyStimulus("denormInexact",1'b0, 8'd1,   28'h2000004, 0, 0);
        applyStimulus("worstShift",   1'b1, 8'd200, 28'h0000001, 0, 29);
        applyStimulus("holdReady",    1'b1, 8'd130, 28'h5A5A5A5, 5, 0);

        $display("[TB] reset mid-normalize");
        in_sign  = 1'b0;
        in_exp   = 8'd200;
        in_sig   = 28'h0000001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midNorm_busy", {30'd0, out_valid, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midNorm_asyncReset", {30'd0, out_valid, in_ready}, 32'd1);
        checkOutput("midNorm_resetResult", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus("afterReset", 1'b0, 8'd127, 28'h8000000, 0, 4);

        $display("[TB] random vectors");
        for (int n = 0; n < 150; n++) begin
            mode = $urandom_range(0, 2);
            case (mode)
                0:       rExp = 8'($urandom_range(0, 255));
                1:       rExp = 8'($urandom_range(0, 30));
                default: rExp = 8'($urandom_range(235, 255));
            endcase
            rSig = 28'(($urandom() & 32'h0FFF_FFFF) >> $urandom_range(0, 27));
            applyStimulus("random", 1'($urandom_range(0, 1)), rExp, rSig, $urandom_range(0, 2), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, miscompares);
        $finish;
    end

endmodule
